// File: rtl/fft_wb_pkg.sv
// Shared types and sizing helpers for the FFT writeback stage.
package fft_wb_pkg;

  // Stream controller states: waiting for an item, or emitting its beats.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  localparam int INW_DEF   = 512;
  localparam int DATAW_DEF = 16;
  localparam int ADDRW_DEF = 32;
  localparam int REGW_DEF  = 3;

  // Samples carried by one item.
  function automatic int calc_nbeats(input int inw, input int dataw);
    return inw / dataw;
  endfunction

  // Beat counter width; never narrower than one bit.
  function automatic int calc_cntw(input int nbeats);
    return (nbeats > 1) ? $clog2(nbeats) : 1;
  endfunction

endpackage

// File: rtl/fft_writeback_stage_serializer.sv
// Splits one INW-bit item into DATAW-bit samples on a valid/ready port.
module fft_beat_serializer
  import fft_wb_pkg::*;
#(
  parameter int INW   = INW_DEF,
  parameter int DATAW = DATAW_DEF,
  parameter int ADDRW = ADDRW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             load,
  input  logic [INW-1:0]   load_data,
  input  logic [ADDRW-1:0] load_addr,
  input  logic             fft_ready,
  output logic             fft_valid,
  output logic [ADDRW-1:0] fft_addr,
  output logic [DATAW-1:0] fft_data,
  output logic             fft_last,
  output logic             busy,
  output logic             last_hs
);

  localparam int NBEATS = calc_nbeats(INW, DATAW);
  localparam int CNTW   = calc_cntw(NBEATS);
  localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(NBEATS - 1);

  state_e           state_q, state_d;
  logic [INW-1:0]   shift_q, shift_d;
  logic [ADDRW-1:0] addr_q,  addr_d;
  logic [CNTW-1:0]  cnt_q,   cnt_d;
  logic             last_q,  last_d;
  logic             hs_s;
  logic [CNTW-1:0]  cnt_inc_s;

  assign hs_s      = (state_q == STREAM) && fft_ready;
  assign last_hs   = hs_s && (cnt_q == LAST_BEAT);
  assign cnt_inc_s = cnt_q + CNTW'(1);

  // State register; reset abandons any item in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: flush wins, a new load (re)enters STREAM, final handshake retires.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else if (load) begin
      state_d = STREAM;
    end else if (last_hs) begin
      state_d = IDLE;
    end else begin
      state_d = state_q;
    end
  end

  // Datapath registers: shift register, sample address, beat counter, last flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Datapath next values: load a fresh item, or advance one beat per handshake.
  always_comb begin
    shift_d = shift_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (flush) begin
      cnt_d  = '0;
      last_d = 1'b0;
    end else if (load) begin
      shift_d = load_data;
      addr_d  = load_addr;
      cnt_d   = '0;
      last_d  = (NBEATS == 1);
    end else if (hs_s) begin
      shift_d = shift_q >> DATAW;
      addr_d  = addr_q + ADDRW'(1);
      cnt_d   = cnt_inc_s;
      last_d  = (cnt_inc_s == LAST_BEAT) && (cnt_q != LAST_BEAT);
    end else begin
      shift_d = shift_q;
    end
  end

  // Port outputs, all taken straight from registers so they hold while not ready.
  always_comb begin
    fft_valid = (state_q == STREAM);
    busy      = (state_q == STREAM);
    fft_data  = shift_q[DATAW-1:0];
    fft_addr  = addr_q;
    fft_last  = last_q;
  end

endmodule

// File: rtl/fft_writeback_stage.sv
// Final pipeline stage: commits register writes and streams FFT items as samples.
module fft_writeback_stage
  import fft_wb_pkg::*;
#(
  parameter int INW   = INW_DEF,
  parameter int DATAW = DATAW_DEF,
  parameter int ADDRW = ADDRW_DEF,
  parameter int REGW  = REGW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             valid_in,
  input  logic             fft_wr_en_in,
  input  logic             reg_wr_en_in,
  input  logic [REGW-1:0]  wr_reg_in,
  input  logic [ADDRW-1:0] addr_in,
  input  logic [INW-1:0]   data_in,
  output logic             stall_out,
  output logic             rf_wr_en,
  output logic [REGW-1:0]  rf_wr_reg,
  output logic [INW-1:0]   rf_wr_data,
  output logic             fft_valid,
  input  logic             fft_ready,
  output logic [ADDRW-1:0] fft_addr,
  output logic [DATAW-1:0] fft_data,
  output logic             fft_last,
  output logic             busy
);

  logic            accept_s;
  logic            load_s;
  logic            busy_s;
  logic            last_hs_s;
  logic            rf_wr_en_q,   rf_wr_en_d;
  logic [REGW-1:0] rf_wr_reg_q,  rf_wr_reg_d;
  logic [INW-1:0]  rf_wr_data_q, rf_wr_data_d;

  // The final handshake frees the stage in the same cycle, so the next item
  // can be taken without a bubble; this makes stall depend on fft_ready.
  assign stall_out = busy_s && !last_hs_s;
  assign accept_s  = valid_in && !stall_out && !flush;
  assign load_s    = accept_s && fft_wr_en_in;
  assign busy      = busy_s;

  fft_beat_serializer #(
    .INW   (INW),
    .DATAW (DATAW),
    .ADDRW (ADDRW)
  ) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .load      (load_s),
    .load_data (data_in),
    .load_addr (addr_in),
    .fft_ready (fft_ready),
    .fft_valid (fft_valid),
    .fft_addr  (fft_addr),
    .fft_data  (fft_data),
    .fft_last  (fft_last),
    .busy      (busy_s),
    .last_hs   (last_hs_s)
  );

  // Register-file write request: a one-cycle strobe per accepted register item.
  always_comb begin
    rf_wr_en_d   = 1'b0;
    rf_wr_reg_d  = rf_wr_reg_q;
    rf_wr_data_d = rf_wr_data_q;
    if (accept_s && reg_wr_en_in) begin
      rf_wr_en_d   = 1'b1;
      rf_wr_reg_d  = wr_reg_in;
      rf_wr_data_d = data_in;
    end else begin
      rf_wr_en_d   = 1'b0;
    end
  end

  // Register-file write port registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wr_en_q   <= 1'b0;
      rf_wr_reg_q  <= '0;
      rf_wr_data_q <= '0;
    end else begin
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_reg_q  <= rf_wr_reg_d;
      rf_wr_data_q <= rf_wr_data_d;
    end
  end

  assign rf_wr_en   = rf_wr_en_q;
  assign rf_wr_reg  = rf_wr_reg_q;
  assign rf_wr_data = rf_wr_data_q;

endmodule

// File: tb/tb_fft_writeback_stage.sv
// Directed self-checking bench for fft_writeback_stage.
module tb_fft_writeback_stage;

  localparam int INW   = 512;
  localparam int DATAW = 16;
  localparam int ADDRW = 32;
  localparam int REGW  = 3;
  localparam int NB    = INW / DATAW;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             valid_in;
  logic             fft_wr_en_in;
  logic             reg_wr_en_in;
  logic [REGW-1:0]  wr_reg_in;
  logic [ADDRW-1:0] addr_in;
  logic [INW-1:0]   data_in;
  logic             stall_out;
  logic             rf_wr_en;
  logic [REGW-1:0]  rf_wr_reg;
  logic [INW-1:0]   rf_wr_data;
  logic             fft_valid;
  logic             fft_ready;
  logic [ADDRW-1:0] fft_addr;
  logic [DATAW-1:0] fft_data;
  logic             fft_last;
  logic             busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fft_writeback_stage #(.INW(INW), .DATAW(DATAW), .ADDRW(ADDRW), .REGW(REGW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .valid_in(valid_in),
    .fft_wr_en_in(fft_wr_en_in), .reg_wr_en_in(reg_wr_en_in), .wr_reg_in(wr_reg_in),
    .addr_in(addr_in), .data_in(data_in), .stall_out(stall_out), .rf_wr_en(rf_wr_en),
    .rf_wr_reg(rf_wr_reg), .rf_wr_data(rf_wr_data), .fft_valid(fft_valid),
    .fft_ready(fft_ready), .fft_addr(fft_addr), .fft_data(fft_data),
    .fft_last(fft_last), .busy(busy)
  );

  task automatic chk(input string tag, input logic [INW-1:0] obs, input logic [INW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Item whose sample i equals i*mul+off (16-bit wrap).
  function automatic logic [INW-1:0] mk_item(input int mul, input int off);
    logic [INW-1:0] v;
    v = '0;
    for (int i = 0; i < NB; i++) v[i*DATAW +: DATAW] = DATAW'(i * mul + off);
    return v;
  endfunction

  // Checks one streaming beat against expected address/sample/last.
  task automatic chk_beat(input string tag, input logic [ADDRW-1:0] ea,
                          input logic [DATAW-1:0] ed, input logic el);
    chk({tag, "_valid"}, INW'(fft_valid), INW'(1'b1));
    chk({tag, "_addr"},  INW'(fft_addr),  INW'(ea));
    chk({tag, "_data"},  INW'(fft_data),  INW'(ed));
    chk({tag, "_last"},  INW'(fft_last),  INW'(el));
  endtask

  logic [INW-1:0] a5_item, seq_item, bp_item;
  int k;
  int cyc;

  initial begin
    rst_n = 1'b0; flush = 1'b0; valid_in = 1'b0; fft_wr_en_in = 1'b0;
    reg_wr_en_in = 1'b0; wr_reg_in = '0; addr_in = '0; data_in = '0; fft_ready = 1'b0;
    a5_item  = {64{8'hA5}};
    seq_item = mk_item(1, 0);
    bp_item  = mk_item(3, 7);

    // Reset state
    #12;
    chk("rst_rf_wr_en", INW'(rf_wr_en), '0);
    chk("rst_rf_wr_data", rf_wr_data, '0);
    chk("rst_fft_valid", INW'(fft_valid), '0);
    chk("rst_fft_addr", INW'(fft_addr), '0);
    chk("rst_stall", INW'(stall_out), '0);
    chk("rst_busy", INW'(busy), '0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // 1. Register write only
    valid_in = 1'b1; reg_wr_en_in = 1'b1; wr_reg_in = 3'd5; data_in = a5_item;
    #1 chk("t1_stall_pre", INW'(stall_out), '0);
    tick();
    valid_in = 1'b0; reg_wr_en_in = 1'b0;
    chk("t1_rf_wr_en", INW'(rf_wr_en), INW'(1'b1));
    chk("t1_rf_wr_reg", INW'(rf_wr_reg), INW'(3'd5));
    chk("t1_rf_wr_data", rf_wr_data, a5_item);
    chk("t1_fft_valid", INW'(fft_valid), '0);
    chk("t1_stall", INW'(stall_out), '0);
    tick();
    chk("t1_rf_wr_en_drop", INW'(rf_wr_en), '0);

    // 2. FFT item with ready held high
    fft_ready = 1'b1;
    valid_in = 1'b1; fft_wr_en_in = 1'b1; addr_in = 32'h0000_0100; data_in = seq_item;
    tick();
    valid_in = 1'b0; fft_wr_en_in = 1'b0;
    for (int i = 0; i < NB; i++) begin
      #1;
      chk_beat("t2", 32'h0000_0100 + ADDRW'(i), DATAW'(i), (i == NB - 1));
      chk("t2_stall", INW'(stall_out), INW'(i != NB - 1));
      tick();
    end
    chk("t2_valid_end", INW'(fft_valid), '0);
    chk("t2_busy_end", INW'(busy), '0);

    // 3. Random backpressure
    valid_in = 1'b1; fft_wr_en_in = 1'b1; addr_in = 32'h0000_0040; data_in = bp_item;
    fft_ready = 1'b0;
    tick();
    valid_in = 1'b0; fft_wr_en_in = 1'b0;
    k = 0; cyc = 0;
    while (k < NB && cyc < 600) begin
      fft_ready = 1'($urandom_range(0, 1));
      #1;
      chk_beat("t3", 32'h0000_0040 + ADDRW'(k), DATAW'(k * 3 + 7), (k == NB - 1));
      chk("t3_stall", INW'(stall_out), INW'(!(fft_ready && k == NB - 1)));
      if (fft_ready) k++;
      cyc++;
      tick();
    end
    chk("t3_all_beats", INW'(k), INW'(NB));
    fft_ready = 1'b1;
    #1 chk("t3_valid_end", INW'(fft_valid), '0);

    // 4. Back-to-back items; the second also writes register 3
    valid_in = 1'b1; fft_wr_en_in = 1'b1; addr_in = 32'h0000_0180; data_in = seq_item;
    tick();
    addr_in = 32'h0000_0200; data_in = bp_item; reg_wr_en_in = 1'b1; wr_reg_in = 3'd3;
    for (int n = 0; n < 2 * NB; n++) begin
      if (n == NB) begin
        valid_in = 1'b0; fft_wr_en_in = 1'b0; reg_wr_en_in = 1'b0;
        chk("t4_rf_wr_en", INW'(rf_wr_en), INW'(1'b1));
        chk("t4_rf_wr_reg", INW'(rf_wr_reg), INW'(3'd3));
        chk("t4_rf_wr_data", rf_wr_data, bp_item);
      end else begin
        chk("t4_rf_wr_en_idle", INW'(rf_wr_en), '0);
      end
      #1;
      if (n < NB) chk_beat("t4a", 32'h0000_0180 + ADDRW'(n), DATAW'(n), (n == NB - 1));
      else        chk_beat("t4b", 32'h0000_0200 + ADDRW'(n - NB), DATAW'((n - NB) * 3 + 7), (n == 2 * NB - 1));
      tick();
    end
    chk("t4_valid_end", INW'(fft_valid), '0);

    // 5. Address wrap
    valid_in = 1'b1; fft_wr_en_in = 1'b1; addr_in = 32'hFFFF_FFF0; data_in = seq_item;
    tick();
    valid_in = 1'b0; fft_wr_en_in = 1'b0;
    for (int i = 0; i < NB; i++) begin
      #1;
      chk_beat("t5", 32'hFFFF_FFF0 + ADDRW'(i), DATAW'(i), (i == NB - 1));
      if (i == 16) chk("t5_wrap_zero", INW'(fft_addr), INW'(32'h0000_0000));
      tick();
    end

    // 6a. Flush at beat 10, then a normal item
    valid_in = 1'b1; fft_wr_en_in = 1'b1; addr_in = 32'h0000_0500; data_in = seq_item;
    tick();
    valid_in = 1'b0; fft_wr_en_in = 1'b0;
    repeat (10) tick();
    #1 chk_beat("t6_b10", 32'h0000_050A, 16'd10, 1'b0);
    flush = 1'b1;
    valid_in = 1'b1; fft_wr_en_in = 1'b1; addr_in = 32'h0000_0600; data_in = bp_item;
    tick();
    flush = 1'b0; valid_in = 1'b0; fft_wr_en_in = 1'b0;
    chk("t6_flush_valid", INW'(fft_valid), '0);
    chk("t6_flush_busy", INW'(busy), '0);
    chk("t6_flush_stall", INW'(stall_out), '0);
    valid_in = 1'b1; fft_wr_en_in = 1'b1; addr_in = 32'h0000_0700; data_in = bp_item;
    tick();
    valid_in = 1'b0; fft_wr_en_in = 1'b0;
    #1 chk_beat("t6_new", 32'h0000_0700, 16'd7, 1'b0);
    chk("t6_new_stall", INW'(stall_out), INW'(1'b1));

    // 6b. Asynchronous reset mid-stream, away from any clock edge
    repeat (3) tick();
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", INW'(fft_valid), '0);
    chk("t6_rst_addr", INW'(fft_addr), '0);
    chk("t6_rst_data", INW'(fft_data), '0);
    chk("t6_rst_last", INW'(fft_last), '0);
    chk("t6_rst_stall", INW'(stall_out), '0);
    chk("t6_rst_busy", INW'(busy), '0);
    chk("t6_rst_rf_wr_en", INW'(rf_wr_en), '0);
    chk("t6_rst_rf_wr_data", rf_wr_data, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_writeback_stage.md
Name: fft_writeback_stage

Overview:
Final pipeline stage. It consumes the memory/writeback pipe register outputs and commits each retired item.
- Register writes go to the 512-bit vector register file.
- FFT writes are serialized into DATAW-bit samples and sent to the FFT engine input port over a valid/ready handshake.
- While a stream is in progress, the stage asserts stall back to the memory/writeback pipe so the next item holds.

Parameters:
INW, 512, width of data item
DATAW, 16, FFT sample width; INW must be a multiple of DATAW
ADDRW, 32, FFT sample address width
REGW, 3, register index width
NBEATS (localparam), INW/DATAW = 32, samples per FFT item
CNTW (localparam), $clog2(NBEATS), beat counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  synchronous abort of in-flight work
valid_in  in  1  item valid, from pipe valid_out
fft_wr_en_in  in  1  item is an FFT write
reg_wr_en_in  in  1  item is a register write
wr_reg_in  in  REGW  destination register
addr_in  in  ADDRW  FFT base sample address
data_in  in  INW  item data
stall_out  out  1  to pipe stall; holds the pipe
rf_wr_en  out  1  register file write strobe
rf_wr_reg  out  REGW  register file index
rf_wr_data  out  INW  register file data
fft_valid  out  1  sample valid
fft_ready  in  1  FFT engine accepts sample
fft_addr  out  ADDRW  sample address
fft_data  out  DATAW  sample
fft_last  out  1  final sample of item
busy  out  1  state == STREAM

Behaviour:
- Reset: asynchronous, active-low; clock is clk.
  - rst_n low forces state IDLE, beat counter 0, and shift register 0.
  - All registered outputs go to 0: rf_wr_en, rf_wr_reg, rf_wr_data, fft_valid, fft_addr, fft_data, fft_last.
  - stall_out=0 and busy=0.
  - Reset asserted mid-stream abandons the item with no completion.
- States: IDLE, STREAM.
- Accept: accept = valid_in && !stall_out && !flush. Items with valid_in=0 are ignored. An accepted item with both enables 0 is consumed with no effect.
- Register write:
  - On accept with reg_wr_en_in, the next cycle has rf_wr_en=1 for exactly one cycle, with rf_wr_reg=wr_reg_in and rf_wr_data=data_in.
  - rf_wr_en=0 otherwise. Latency is 1.
- FFT write:
  - On accept with fft_wr_en_in: load the shift register with data_in, base address with addr_in, counter=0, and state goes to STREAM.
  - The first beat is visible the following cycle.
  - An item with both enables set does the register write and the stream concurrently.
- STREAM beats:
  - fft_valid=1.
  - fft_data = data_in[k*DATAW +: DATAW] for beat k (low sample first).
  - fft_addr = base + k, modulo 2^ADDRW (wraps).
  - fft_last = (k == NBEATS-1).
- Handshake:
  - A beat transfers when fft_valid && fft_ready; then the shift register moves right by DATAW and the counter increments.
  - While fft_ready=0, fft_valid, fft_data, fft_addr and fft_last hold stable.
- Completion: last_hs = STREAM && fft_ready && (k == NBEATS-1).
  - On last_hs, go to IDLE, or reload directly into STREAM if a new FFT item is accepted the same cycle.
  - Back-to-back items therefore stream with no bubble.
- Stall: stall_out = (state==STREAM) && !last_hs. This is combinational from fft_ready; the pipe tolerates this path.
- Flush:
  - Next state is IDLE, counter 0, fft_valid=0 next cycle, rf_wr_en=0 next cycle.
  - Flush overrides an accept or last_hs in the same cycle; the item is dropped.
  - Dropping fft_valid without a handshake is legal only on flush.
- Minimum item time with fft_ready held high: NBEATS cycles.

Decomposition:
- Package fft_wb_pkg: state enum (IDLE, STREAM); NBEATS and CNTW computed from INW and DATAW.
- One sub-module, fft_beat_serializer: INW shift register, beat counter, address incrementer, and the valid/last/handshake logic.
- The top level keeps the accept/stall logic and the register file write register.

Test Plan:
1. Register write only: valid_in=1, reg_wr_en_in=1, wr_reg_in=5, data_in=0xA5…A5.
   -> next cycle rf_wr_en=1, rf_wr_reg=5, rf_wr_data=0xA5…A5; stall_out never asserts; fft_valid stays 0.
2. FFT item, fft_ready=1: addr_in=0x100, sample i = i.
   -> 32 consecutive beats, fft_addr 0x100..0x11F, fft_data 0..31, fft_last only on the 0x11F beat.
   -> stall_out high for 31 cycles, low on the last beat.
3. Backpressure: fft_ready random 50%.
   -> beats hold stable while ready=0; all 32 samples arrive in order exactly once.
4. Back-to-back FFT items, fft_ready=1: second item base 0x200.
   -> 64 contiguous beats, no bubble; the second item's beats are 0x200..0x21F.
   -> One item with both enables set produces rf_wr_en the cycle after accept while its stream starts.
5. Address wrap: addr_in=0xFFFFFFF0.
   -> beats 0..15 address 0xFFFFFFF0..0xFFFFFFFF; beat 16 address 0x00000000.
6. Flush and reset:
   - flush at beat 10 -> next cycle fft_valid=0, busy=0, stall_out=0, and the next item is accepted normally.
   - rst_n low mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
